// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer: chooses the next PC, holds redirects that arrive while fetch
// is stalled, and tracks in-flight fetches so responses from a squashed path are dropped.
module pc_redirect_ctrl #(
    parameter int unsigned     RegW       = 32,
    parameter logic [RegW-1:0] START_ADDR = RegW'(32'h1C000000),
    parameter int unsigned     MAX_OUTST  = 4,
    parameter int unsigned     CNT_W      = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [RegW-1:0] pc_i,
    input  logic            allow_nxt_pc_i,
    input  logic            excp_valid_i,
    input  logic [RegW-1:0] excp_pc_i,
    input  logic            flush_valid_i,
    input  logic [RegW-1:0] flush_pc_i,
    input  logic            pred_taken_i,
    input  logic [RegW-1:0] pred_target_i,
    input  logic            req_fire_i,
    input  logic            resp_valid_i,
    output logic            pc_we_o,
    output logic [RegW-1:0] pc_next_o,
    output logic            if_flush_o,
    output logic            req_ready_o,
    output logic            resp_ok_o,
    output logic            draining_o
);

    localparam logic [1:0]       RankExcp  = 2'd3;
    localparam logic [1:0]       RankFlush = 2'd2;
    localparam logic [CNT_W-1:0] MaxOutst  = CNT_W'(MAX_OUTST);

    logic             pend_valid_q, pend_valid_d;
    logic [RegW-1:0]  pend_pc_q, pend_pc_d;
    logic [1:0]       pend_rank_q, pend_rank_d;
    logic             pend_boot_q, pend_boot_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;

    logic             redir_now;
    logic [1:0]       new_rank;
    logic [RegW-1:0]  redir_pc;
    logic [RegW-3:0]  seq_hi;
    logic [RegW-1:0]  seq_pc;
    logic [RegW-1:0]  winner;

    assign redir_now = excp_valid_i | flush_valid_i;
    assign new_rank  = excp_valid_i ? RankExcp : RankFlush;
    assign redir_pc  = excp_valid_i ? excp_pc_i : flush_pc_i;
    // Increment above the byte offset only; the low two bits pass through unchanged.
    assign seq_hi    = pc_i[RegW-1:2] + (RegW-2)'(1);
    assign seq_pc    = {seq_hi, pc_i[1:0]};

    always_comb begin
        winner = seq_pc;
        if (excp_valid_i) begin
            winner = excp_pc_i;
        end else if (flush_valid_i) begin
            winner = flush_pc_i;
        end else if (pend_valid_q) begin
            winner = pend_pc_q;
        end else if (pred_taken_i) begin
            winner = pred_target_i;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_rank_d  = pend_rank_q;
        pend_boot_d  = pend_boot_q;
        if (allow_nxt_pc_i) begin
            pend_valid_d = 1'b0;
            pend_boot_d  = 1'b0;
        end else if (redir_now && (!pend_valid_q || new_rank >= pend_rank_q)) begin
            // A lower-ranked redirect never displaces a held higher-ranked one.
            pend_valid_d = 1'b1;
            pend_pc_d    = redir_pc;
            pend_rank_d  = new_rank;
            pend_boot_d  = 1'b0;
        end
    end

    always_comb begin
        out_cnt_d  = out_cnt_q + CNT_W'(req_fire_i) - CNT_W'(resp_valid_i);
        disc_cnt_d = disc_cnt_q;
        if (redir_now) begin
            // Everything still in flight after this cycle, including this cycle's request, is stale.
            disc_cnt_d = out_cnt_d;
        end else if (resp_valid_i && disc_cnt_q != '0) begin
            disc_cnt_d = disc_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_valid_q <= 1'b1;
            pend_pc_q    <= START_ADDR;
            pend_rank_q  <= RankExcp;
            pend_boot_q  <= 1'b1;
            out_cnt_q    <= '0;
            disc_cnt_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_rank_q  <= pend_rank_d;
            pend_boot_q  <= pend_boot_d;
            out_cnt_q    <= out_cnt_d;
            disc_cnt_q   <= disc_cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held, with the boot vector on pc_next_o.
    always_comb begin
        pc_we_o     = 1'b0;
        pc_next_o   = START_ADDR;
        if_flush_o  = 1'b0;
        req_ready_o = 1'b0;
        resp_ok_o   = 1'b0;
        draining_o  = 1'b0;
        if (rst_n_i) begin
            pc_we_o     = allow_nxt_pc_i;
            pc_next_o   = winner;
            if_flush_o  = redir_now | (pend_valid_q & ~pend_boot_q & allow_nxt_pc_i);
            req_ready_o = out_cnt_q < MaxOutst;
            resp_ok_o   = resp_valid_i & ~redir_now & (disc_cnt_q == '0);
            draining_o  = disc_cnt_q != '0;
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic, checked against
// a model that tracks in-flight fetches as a queue of tagged requests.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] Start = 32'h1C000000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] pc_i, excp_pc_i, flush_pc_i, pred_target_i;
    logic        allow_nxt_pc_i, excp_valid_i, flush_valid_i, pred_taken_i;
    logic        req_fire_i, resp_valid_i;
    logic        pc_we_o, if_flush_o, req_ready_o, resp_ok_o, draining_o;
    logic [31:0] pc_next_o;

    always #5 clk_i = ~clk_i;

    pc_redirect_ctrl #(
        .RegW       (32),
        .START_ADDR (Start),
        .MAX_OUTST  (4),
        .CNT_W      (3)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .pc_i           (pc_i),
        .allow_nxt_pc_i (allow_nxt_pc_i),
        .excp_valid_i   (excp_valid_i),
        .excp_pc_i      (excp_pc_i),
        .flush_valid_i  (flush_valid_i),
        .flush_pc_i     (flush_pc_i),
        .pred_taken_i   (pred_taken_i),
        .pred_target_i  (pred_target_i),
        .req_fire_i     (req_fire_i),
        .resp_valid_i   (resp_valid_i),
        .pc_we_o        (pc_we_o),
        .pc_next_o      (pc_next_o),
        .if_flush_o     (if_flush_o),
        .req_ready_o    (req_ready_o),
        .resp_ok_o      (resp_ok_o),
        .draining_o     (draining_o)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: held redirect plus a queue of in-flight requests (1 = stale path).
    bit          m_pv, m_pboot;
    logic [31:0] m_ppc, m_win, pc_reg;
    int          m_prank;
    bit          m_q[$];

    task automatic model_reset();
        m_pv = 1; m_ppc = Start; m_prank = 3; m_pboot = 1;
        m_q.delete();
    endtask

    function automatic bit any_stale();
        foreach (m_q[i]) if (m_q[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_win();
        if (excp_valid_i) return excp_pc_i;
        if (flush_valid_i) return flush_pc_i;
        if (m_pv) return m_ppc;
        if (pred_taken_i) return pred_target_i;
        return ((pc_i & 32'hFFFF_FFFC) + 32'd4) | (pc_i & 32'd3);
    endfunction

    task automatic idle();
        allow_nxt_pc_i = 0; excp_valid_i = 0; flush_valid_i = 0; pred_taken_i = 0;
        req_fire_i = 0; resp_valid_i = 0;
        excp_pc_i = 0; flush_pc_i = 0; pred_target_i = 0;
    endtask

    task automatic check_outputs();
        bit redir;
        redir = excp_valid_i | flush_valid_i;
        m_win = model_win();
        assert (!(req_fire_i && !req_ready_o)) else $error("req_fire_i while not ready");
        assert (!(resp_valid_i && !req_fire_i && m_q.size() == 0))
            else $error("resp_valid_i with nothing outstanding");
        check_eq("pc_we", pc_we_o, allow_nxt_pc_i);
        check_eq("pc_next", pc_next_o, m_win);
        check_eq("if_flush", if_flush_o, redir | (m_pv & allow_nxt_pc_i & !m_pboot));
        check_eq("req_ready", req_ready_o, m_q.size() < 4);
        check_eq("resp_ok", resp_ok_o, resp_valid_i & !redir & !any_stale());
        check_eq("draining", draining_o, any_stale());
    endtask

    task automatic clk_adv();
        int rank;
        @(posedge clk_i);
        if (allow_nxt_pc_i) begin
            m_pv = 0; m_pboot = 0;
            pc_reg = m_win;
        end else if (excp_valid_i || flush_valid_i) begin
            rank = excp_valid_i ? 3 : 2;
            if (!m_pv || rank >= m_prank) begin
                m_pv = 1; m_pboot = 0; m_prank = rank;
                m_ppc = excp_valid_i ? excp_pc_i : flush_pc_i;
            end
        end
        if (req_fire_i) m_q.push_back(1'b0);
        if (resp_valid_i && m_q.size() > 0) void'(m_q.pop_front());
        if (excp_valid_i || flush_valid_i) foreach (m_q[i]) m_q[i] = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic step();
        #1;
        check_outputs();
        clk_adv();
    endtask

    initial begin
        idle();
        pc_i = 0;
        model_reset();
        pc_reg = Start;
        repeat (2) @(negedge clk_i);

        // Outputs while reset is held, even with requests present.
        allow_nxt_pc_i = 1; excp_valid_i = 1; excp_pc_i = 32'h1C00_7000;
        #1;
        check_eq("rst_pc_we", pc_we_o, 0);
        check_eq("rst_pc_next", pc_next_o, Start);
        check_eq("rst_if_flush", if_flush_o, 0);
        check_eq("rst_req_ready", req_ready_o, 0);
        idle();
        @(negedge clk_i);
        rst_n_i = 1;

        // Boot
        allow_nxt_pc_i = 1; pc_i = 32'h0;
        #1; check_outputs();
        check_eq("boot_next", pc_next_o, Start);
        check_eq("boot_flush", if_flush_o, 0);
        clk_adv();
        pc_i = Start;
        #1; check_outputs();
        check_eq("boot_seq", pc_next_o, 32'h1C00_0004);
        clk_adv();

        // Stalled flush held across idle stall cycles
        idle(); pc_i = 32'h1C00_0004;
        flush_valid_i = 1; flush_pc_i = 32'h1C00_0100;
        step();
        idle();
        repeat (3) step();
        allow_nxt_pc_i = 1;
        #1; check_outputs();
        check_eq("held_flush_pc", pc_next_o, 32'h1C00_0100);
        check_eq("held_flush_kill", if_flush_o, 1);
        clk_adv();
        pc_i = 32'h1C00_0100;
        #1; check_outputs();
        check_eq("pend_cleared", pc_next_o, 32'h1C00_0104);
        check_eq("pend_cleared_kill", if_flush_o, 0);
        clk_adv();

        // Priority between held excp and later flush, then same-cycle excp+flush
        idle(); excp_valid_i = 1; excp_pc_i = 32'h1C00_8000;
        step();
        idle(); flush_valid_i = 1; flush_pc_i = 32'h1C00_0200;
        step();
        idle(); allow_nxt_pc_i = 1;
        #1; check_outputs();
        check_eq("excp_kept", pc_next_o, 32'h1C00_8000);
        clk_adv();
        excp_valid_i = 1; flush_valid_i = 1;
        excp_pc_i = 32'h1C00_A000; flush_pc_i = 32'h1C00_0300;
        #1; check_outputs();
        check_eq("excp_over_flush", pc_next_o, 32'h1C00_A000);
        clk_adv();

        // Predicted vs sequential, including wrap
        idle(); allow_nxt_pc_i = 1;
        pc_i = 32'h1C00_0010; pred_taken_i = 1; pred_target_i = 32'h1C00_0040;
        #1; check_outputs(); check_eq("pred_taken", pc_next_o, 32'h1C00_0040); clk_adv();
        pred_taken_i = 0;
        #1; check_outputs(); check_eq("seq", pc_next_o, 32'h1C00_0014); clk_adv();
        pc_i = 32'hFFFF_FFFC;
        #1; check_outputs(); check_eq("seq_wrap", pc_next_o, 32'h0); clk_adv();

        // Discard after a flush with a same-cycle request
        idle(); req_fire_i = 1;
        repeat (3) step();
        flush_valid_i = 1; flush_pc_i = 32'h1C00_0400; allow_nxt_pc_i = 1;
        step();
        idle();
        #1; check_outputs();
        check_eq("drain_on", draining_o, 1);
        check_eq("full_after_flush", req_ready_o, 0);
        clk_adv();
        for (int i = 0; i < 5; i++) begin
            idle(); resp_valid_i = 1;
            if (i == 1) req_fire_i = 1;
            #1; check_outputs();
            check_eq($sformatf("drain_resp%0d", i), resp_ok_o, (i == 4));
            if (i == 4) check_eq("drain_done", draining_o, 0);
            clk_adv();
        end

        // Backpressure, then reset asserted mid-drain
        idle(); req_fire_i = 1;
        repeat (4) step();
        idle();
        #1; check_outputs(); check_eq("bp_full", req_ready_o, 0); clk_adv();
        resp_valid_i = 1; step();
        idle();
        #1; check_outputs(); check_eq("bp_free", req_ready_o, 1); clk_adv();
        flush_valid_i = 1; flush_pc_i = 32'h1C00_0500; step();
        idle(); allow_nxt_pc_i = 1;
        #1; check_eq("mid_drain", draining_o, 1);
        #1; rst_n_i = 0;
        #1;
        check_eq("async_drain", draining_o, 0);
        check_eq("async_pc_we", pc_we_o, 0);
        check_eq("async_pc_next", pc_next_o, Start);
        model_reset(); pc_reg = Start;
        @(negedge clk_i);
        rst_n_i = 1; pc_i = 32'h1C00_0600;
        #1; check_outputs();
        check_eq("reboot_pc", pc_next_o, Start);
        check_eq("reboot_kill", if_flush_o, 0);
        check_eq("reboot_ready", req_ready_o, 1);
        clk_adv();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n_i = 0;
                #1;
                check_eq("rand_rst_drain", draining_o, 0);
                check_eq("rand_rst_pc", pc_next_o, Start);
                model_reset(); pc_reg = Start;
                @(negedge clk_i);
                rst_n_i = 1;
            end
            allow_nxt_pc_i = $urandom_range(0, 3) != 0;
            excp_valid_i   = $urandom_range(0, 15) == 0;
            flush_valid_i  = $urandom_range(0, 7) == 0;
            pred_taken_i   = $urandom_range(0, 2) == 0;
            excp_pc_i      = $urandom() & 32'hFFFF_FFFC;
            flush_pc_i     = $urandom() & 32'hFFFF_FFFC;
            pred_target_i  = $urandom() & 32'hFFFF_FFFC;
            pc_i           = ($urandom_range(0, 15) == 0) ? 32'($urandom()) : pc_reg;
            req_fire_i     = (m_q.size() < 4) && ($urandom_range(0, 1) == 1);
            resp_valid_i   = (m_q.size() > 0 || req_fire_i) && ($urandom_range(0, 1) == 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch-stage controller that sequences the PC register.
- Every cycle it decides whether the PC advances and to which address: boot vector, exception/ertn target, branch-mispredict flush target, predicted-taken target, or sequential PC+4.
- Holds a redirect that arrives while fetch is stalled until fetch can accept it.
- Counts outstanding instruction-fetch requests so responses belonging to a squashed path are discarded.

Parameters:
- RegW, 32, PC/address width.
- START_ADDR, 32'h1C000000, boot PC.
- MAX_OUTST, 4, maximum in-flight fetch requests.
- CNT_W, 3, width of the outstanding and discard counters; must satisfy 2^CNT_W > MAX_OUTST.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous reset, active low.
- pc_i  in  RegW  current PC register value.
- allow_nxt_pc_i  in  1  fetch can accept a new PC this cycle.
- excp_valid_i  in  1  exception/ertn redirect request.
- excp_pc_i  in  RegW  exception target.
- flush_valid_i  in  1  branch-mispredict redirect.
- flush_pc_i  in  RegW  correct-path PC.
- pred_taken_i  in  1  predictor says taken for pc_i.
- pred_target_i  in  RegW  predicted target.
- req_fire_i  in  1  fetch request issued this cycle.
- resp_valid_i  in  1  fetch response returned this cycle.
- pc_we_o  out  1  load pc_next_o into the PC register.
- pc_next_o  out  RegW  next PC.
- if_flush_o  out  1  kill IF-stage contents.
- req_ready_o  out  1  a new fetch request may be issued.
- resp_ok_o  out  1  the current response is on the correct path.
- draining_o  out  1  stale responses are still expected.

Behaviour:
- Interface rules: single clock domain, clk_i; rst_n_i is asynchronous, active-low.
- Reset state:
  - pend_valid=1, pend_pc=START_ADDR, pend_rank=3 (boot vector).
  - out_cnt=0, disc_cnt=0.
  - While in reset all outputs are 0 except pc_next_o, which reads START_ADDR.
- Redirect present this cycle: redir_now = excp_valid_i | flush_valid_i.
- Winner selection (combinational, fixed priority):
  - 1. excp_pc_i
  - 2. flush_pc_i
  - 3. pend_pc, if pend_valid
  - 4. pred_target_i, if pred_taken_i
  - 5. seq = {pc_i[RegW-1:2]+1, pc_i[1:0]}; wraps modulo 2^RegW with no carry into [1:0].
- pc_we_o = allow_nxt_pc_i; pc_next_o = winner. Zero latency, with the outputs driven in the same cycle as the inputs.
- Pending register update:
  - allow=1: a pending entry used this cycle clears (pend_valid<=0), including when a same-cycle redir_now overrides it.
  - allow=0 and redir_now: rank is 3 for excp, 2 for flush. Capture if !pend_valid or new rank >= pend_rank; otherwise keep the existing entry.
  - allow=0 and both excp and flush valid: excp is captured.
  - Predicted-taken targets are never stored. The predictor re-evaluates once the PC is stable.
- if_flush_o = redir_now | (pend_valid & allow_nxt_pc_i). Not asserted for the boot pending entry.
- Outstanding counter:
  - out_cnt <= out_cnt + req_fire_i - resp_valid_i; simultaneous fire+resp leaves it unchanged.
  - req_ready_o = (out_cnt < MAX_OUTST).
  - req_fire_i while !req_ready_o is illegal; bench assertion.
  - resp_valid_i when out_cnt==0 and !req_fire_i is illegal; bench assertion.
- Discard counter:
  - On redir_now: disc_cnt <= out_cnt + req_fire_i - resp_valid_i. The request issued this cycle fetched the old path, so it is counted as stale.
  - Else if resp_valid_i and disc_cnt!=0: disc_cnt decrements.
- resp_ok_o = resp_valid_i & ~redir_now & (disc_cnt==0). A response arriving in the redirect cycle itself is discarded.
- draining_o = (disc_cnt != 0).
- A second redirect during draining reloads disc_cnt from the live out_cnt; it does not accumulate.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight responses are the memory side's responsibility.

Test Plan:
- Boot: release reset with allow=1 -> first cycle pc_we_o=1, pc_next_o=0x1C000000, if_flush_o=0. Next cycle with pc_i=0x1C000000 -> pc_next_o=0x1C000004.
- Stalled flush: allow=0, flush_valid=1, flush_pc=0x1C000100 for one cycle. Then 3 idle stall cycles. Then allow=1 -> pc_next_o=0x1C000100, if_flush_o=1 that cycle, pend_valid cleared afterwards.
- Priority: allow=0, excp (0x1C008000) one cycle, then flush (0x1C000200) one cycle, then allow=1 -> pc_next_o=0x1C008000. Same-cycle excp+flush with allow=1 -> excp_pc_i chosen.
- Predict vs sequential: pc_i=0x1C000010, pred_taken=1, target=0x1C000040 -> pc_next_o=0x1C000040. pred_taken=0 -> 0x1C000014. pc_i=0xFFFFFFFC -> 0x00000000.
- Discard: issue 3 requests (out_cnt=3), then flush with req_fire=1, resp_valid=0 -> disc_cnt=4, draining_o=1. The next 4 responses give resp_ok_o=0; the 5th gives resp_ok_o=1, draining_o=0.
- Backpressure/reset: issue 4 requests -> req_ready_o=0. One response -> req_ready_o=1. Assert rst_n_i low mid-drain -> out_cnt=disc_cnt=0 and pend_valid=1 asynchronously, before the next clock edge.
